// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the shared memory port arbiter.
// The arbiter connects through the slave modport; the core/memory side uses master.
interface mem_port_arbiter_if #(
   parameter int WIDTH_DATA_LENGTH = 32,
   parameter int WIDTH_ADDR        = 32
);
   logic                         IF_Req;
   logic [WIDTH_ADDR-1:0]        IF_Addr;
   logic [WIDTH_DATA_LENGTH-1:0] IF_Rdata;
   logic                         IF_Ack;
   logic                         MEM_Req;
   logic                         MEM_We;
   logic [WIDTH_ADDR-1:0]        MEM_Addr;
   logic [WIDTH_DATA_LENGTH-1:0] MEM_Wdata;
   logic [WIDTH_DATA_LENGTH-1:0] MEM_Rdata;
   logic                         MEM_Ack;
   logic                         Mem_En;
   logic                         Mem_We;
   logic [WIDTH_ADDR-1:0]        Mem_Addr;
   logic [WIDTH_DATA_LENGTH-1:0] Mem_Wdata;
   logic [WIDTH_DATA_LENGTH-1:0] Mem_Rdata;
   logic                         Stall_Fetch;
   logic                         Stall_Mem;
   logic                         Busy;

   modport slave (
      input  IF_Req, IF_Addr, MEM_Req, MEM_We, MEM_Addr, MEM_Wdata, Mem_Rdata,
      output IF_Rdata, IF_Ack, MEM_Rdata, MEM_Ack, Mem_En, Mem_We, Mem_Addr,
             Mem_Wdata, Stall_Fetch, Stall_Mem, Busy
   );

   modport master (
      output IF_Req, IF_Addr, MEM_Req, MEM_We, MEM_Addr, MEM_Wdata, Mem_Rdata,
      input  IF_Rdata, IF_Ack, MEM_Rdata, MEM_Ack, Mem_En, Mem_We, Mem_Addr,
             Mem_Wdata, Stall_Fetch, Stall_Mem, Busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between fetch (read-only)
// and the memory stage, alternating grants when both request.
//
//   state  | meaning
//   IDLE   | sample requests, pick owner, latch address/data
//   ACCESS | Mem_En strobe for one cycle, load latency counter
//   WAIT   | count down until Mem_Rdata is valid, then capture it
//   DONE   | one-cycle ack to the owner, requests ignored
module mem_port_arbiter #(
   parameter int WIDTH_DATA_LENGTH = 32,
   parameter int WIDTH_ADDR        = 32,
   parameter int MEM_LATENCY       = 2
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   state_t                       r_state;
   state_t                       w_state_nxt;
   logic                         w_grant;
   logic                         w_grant_mem;
   logic                         w_capture;
   logic                         r_last_mem;
   logic                         r_owner_mem;
   logic                         r_we;
   logic [CNT_W-1:0]             r_cnt;
   logic                         r_if_ack;
   logic                         r_mem_ack;
   logic [WIDTH_DATA_LENGTH-1:0] r_if_rdata;
   logic [WIDTH_DATA_LENGTH-1:0] r_mem_rdata;
   logic                         r_mem_en;
   logic                         r_mem_we;
   logic [WIDTH_ADDR-1:0]        r_mem_addr;
   logic [WIDTH_DATA_LENGTH-1:0] r_mem_wdata;
   logic                         r_busy;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Read data is valid MEM_LATENCY cycles after the strobe, i.e. never on the
   // ACCESS edge itself, so WAIT is visited even for a latency of one.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_grant_mem = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.IF_Req || bus.MEM_Req) begin
               w_grant     = 1'b1;
               w_grant_mem = bus.MEM_Req && !(bus.IF_Req && r_last_mem);
               w_state_nxt = ACCESS;
            end
         end
         ACCESS: w_state_nxt = WAIT;
         WAIT: begin
            if (r_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_mem  <= 1'b0;
         r_owner_mem <= 1'b0;
         r_we        <= 1'b0;
         r_cnt       <= '0;
         r_if_ack    <= 1'b0;
         r_mem_ack   <= 1'b0;
         r_if_rdata  <= '0;
         r_mem_rdata <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_mem_en  <= w_grant;
         r_mem_we  <= w_grant & w_grant_mem & bus.MEM_We;
         r_if_ack  <= w_capture & ~r_owner_mem;
         r_mem_ack <= w_capture & r_owner_mem;
         r_busy    <= (w_state_nxt != IDLE);
         if (w_grant) begin
            r_owner_mem <= w_grant_mem;
            r_last_mem  <= w_grant_mem;
            r_we        <= w_grant_mem & bus.MEM_We;
            r_mem_addr  <= w_grant_mem ? bus.MEM_Addr : bus.IF_Addr;
            r_mem_wdata <= w_grant_mem ? bus.MEM_Wdata : '0;
         end
         if (r_state == ACCESS)
            r_cnt <= CNT_LOAD;
         else if (r_state == WAIT && r_cnt != '0)
            r_cnt <= r_cnt - CNT_W'(1);
         if (w_capture && !r_owner_mem)
            r_if_rdata <= bus.Mem_Rdata;
         if (w_capture && r_owner_mem && !r_we)
            r_mem_rdata <= bus.Mem_Rdata;
      end
   end

   assign bus.IF_Ack      = r_if_ack;
   assign bus.MEM_Ack     = r_mem_ack;
   assign bus.IF_Rdata    = r_if_rdata;
   assign bus.MEM_Rdata   = r_mem_rdata;
   assign bus.Mem_En      = r_mem_en;
   assign bus.Mem_We      = r_mem_we;
   assign bus.Mem_Addr    = r_mem_addr;
   assign bus.Mem_Wdata   = r_mem_wdata;
   assign bus.Busy        = r_busy;
   assign bus.Stall_Fetch = bus.IF_Req & ~r_if_ack;
   assign bus.Stall_Mem   = bus.MEM_Req & ~r_mem_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter at latencies 2 and 1, checked against a
// transaction-level model of grant order, access timing and memory contents.
module tb_mem_port_arbiter;
   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int NCYC = 1500;

   logic clk = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   nfin = 0;

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom();
      a[1:0] = 2'b00;
      return a;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_lat
      localparam int LAT = (g == 0) ? 2 : 1;

      logic        rst;
      logic [31:0] ram [16];
      logic [31:0] ref_mem [16];
      int          cyc, ret_cyc, dec, en_c, ack_c, ngrant, if_st, mem_st;
      logic [31:0] ret_data, txn_addr, txn_wdata, txn_rdata;
      logic [31:0] exp_if_rd, exp_mem_rd, exp_addr, exp_wdata;
      bit          own_mem, txn_we, last_mem, exp_if_ack, exp_mem_ack;

      mem_port_arbiter_if #(.WIDTH_DATA_LENGTH(DW), .WIDTH_ADDR(AW)) bus ();

      mem_port_arbiter #(
         .WIDTH_DATA_LENGTH(DW),
         .WIDTH_ADDR(AW),
         .MEM_LATENCY(LAT)
      ) dut (
         .clk(clk),
         .rst(rst),
         .bus(bus)
      );

      task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
         check_val($sformatf("L%0d_%s", LAT, tag), got, exp);
      endtask

      task automatic tick();
         @(posedge clk);
         #1;
         cyc++;
      endtask

      initial begin
         rst           = 1'b1;
         bus.IF_Req    = 1'b0;
         bus.IF_Addr   = '0;
         bus.MEM_Req   = 1'b0;
         bus.MEM_We    = 1'b0;
         bus.MEM_Addr  = '0;
         bus.MEM_Wdata = '0;
         bus.Mem_Rdata = '0;
         for (int i = 0; i < 16; i++) begin
            ram[i]     = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
            ref_mem[i] = ram[i];
         end
         repeat (2) @(posedge clk);
         #1;

         // aborted fetch: request in cycle 0, reset sampled at the end of cycle 2
         cyc         = 0;
         rst         = 1'b0;
         bus.IF_Req  = 1'b1;
         bus.IF_Addr = 32'h10;
         tick();
         chk("abort_en", bus.Mem_En, 1);
         chk("abort_addr", bus.Mem_Addr, 32'h10);
         chk("abort_busy", bus.Busy, 1);
         chk("abort_stall", bus.Stall_Fetch, 1);
         tick();
         rst = 1'b1;
         tick();
         bus.Mem_Rdata = 32'h0050_0093;
         chk("rst_busy", bus.Busy, 0);
         chk("rst_if_ack", bus.IF_Ack, 0);
         chk("rst_mem_ack", bus.MEM_Ack, 0);
         chk("rst_if_rdata", bus.IF_Rdata, 0);
         chk("rst_mem_rdata", bus.MEM_Rdata, 0);
         chk("rst_mem_en", bus.Mem_En, 0);
         chk("rst_mem_we", bus.Mem_We, 0);
         chk("rst_mem_addr", bus.Mem_Addr, 0);
         chk("rst_mem_wdata", bus.Mem_Wdata, 0);
         rst        = 1'b0;
         bus.IF_Req = 1'b0;
         tick();
         chk("late_no_ack", bus.IF_Ack, 0);
         chk("late_rdata", bus.IF_Rdata, 0);
         chk("late_busy", bus.Busy, 0);

         // randomized traffic against the transaction model
         last_mem = 1'b0;  own_mem = 1'b0;  txn_we = 1'b0;
         exp_if_rd = '0;   exp_mem_rd = '0; exp_addr = '0;  exp_wdata = '0;
         txn_addr = '0;    txn_wdata = '0;  txn_rdata = '0; ret_data = '0;
         en_c = -100;      ack_c = -100;    ret_cyc = -100;
         dec = cyc + 1;    ngrant = 0;      if_st = 0;      mem_st = 0;
         for (int n = 0; n < NCYC; n++) begin
            tick();
            exp_if_ack  = (cyc == ack_c) && !own_mem;
            exp_mem_ack = (cyc == ack_c) && own_mem;
            chk("mem_en", bus.Mem_En, 32'(cyc == en_c));
            chk("busy", bus.Busy, 32'((cyc >= en_c) && (cyc <= ack_c)));
            chk("if_ack", bus.IF_Ack, 32'(exp_if_ack));
            chk("mem_ack", bus.MEM_Ack, 32'(exp_mem_ack));
            if (exp_if_ack) exp_if_rd = txn_rdata;
            if (exp_mem_ack && !txn_we) exp_mem_rd = txn_rdata;
            chk("if_rdata", bus.IF_Rdata, exp_if_rd);
            chk("mem_rdata", bus.MEM_Rdata, exp_mem_rd);
            if (cyc == en_c) begin
               exp_addr  = txn_addr;
               exp_wdata = txn_wdata;
               chk("mem_we", bus.Mem_We, 32'(txn_we));
            end
            chk("mem_addr", bus.Mem_Addr, exp_addr);
            chk("mem_wdata", bus.Mem_Wdata, exp_wdata);

            // memory model: responds to the strobe after LAT cycles, noise otherwise
            if (bus.Mem_En) begin
               ret_cyc  = cyc + LAT;
               ret_data = ram[bus.Mem_Addr[5:2]];
               if (bus.Mem_We) ram[bus.Mem_Addr[5:2]] = bus.Mem_Wdata;
            end
            bus.Mem_Rdata = (cyc == ret_cyc) ? ret_data : $urandom();

            if (cyc == ack_c + 1) begin
               if (own_mem) mem_st = 0;
               else         if_st  = 0;
            end
            if (if_st == 0) begin
               if (ngrant < 4 || $urandom_range(0, 3) != 0) begin
                  if_st       = 1;
                  bus.IF_Req  = 1'b1;
                  bus.IF_Addr = rand_addr();
               end else begin
                  bus.IF_Req = 1'b0;
               end
            end else if (if_st == 2) begin
               if ($urandom_range(0, 3) == 0) bus.IF_Addr = rand_addr();
               if ($urandom_range(0, 7) == 0) bus.IF_Req = 1'b0;
            end
            if (mem_st == 0) begin
               if (ngrant < 4 || $urandom_range(0, 3) != 0) begin
                  mem_st        = 1;
                  bus.MEM_Req   = 1'b1;
                  bus.MEM_We    = ($urandom_range(0, 1) == 1);
                  bus.MEM_Addr  = rand_addr();
                  bus.MEM_Wdata = $urandom();
               end else begin
                  bus.MEM_Req = 1'b0;
               end
            end else if (mem_st == 2) begin
               if ($urandom_range(0, 3) == 0) bus.MEM_Addr = rand_addr();
               if ($urandom_range(0, 3) == 0) bus.MEM_Wdata = $urandom();
               if ($urandom_range(0, 3) == 0) bus.MEM_We = ~bus.MEM_We;
               if ($urandom_range(0, 7) == 0) bus.MEM_Req = 1'b0;
            end

            if (cyc == dec) begin
               if (bus.IF_Req || bus.MEM_Req) begin
                  own_mem  = bus.MEM_Req && !(bus.IF_Req && last_mem);
                  last_mem = own_mem;
                  ngrant++;
                  en_c  = cyc + 1;
                  ack_c = cyc + 2 + LAT;
                  dec   = cyc + 3 + LAT;
                  if (own_mem) begin
                     txn_addr  = bus.MEM_Addr;
                     txn_we    = bus.MEM_We;
                     txn_wdata = bus.MEM_Wdata;
                     mem_st    = 2;
                  end else begin
                     txn_addr  = bus.IF_Addr;
                     txn_we    = 1'b0;
                     txn_wdata = '0;
                     if_st     = 2;
                  end
                  txn_rdata = ref_mem[txn_addr[5:2]];
                  if (txn_we) ref_mem[txn_addr[5:2]] = txn_wdata;
               end else begin
                  dec = cyc + 1;
               end
            end

            #1;
            chk("stall_fetch", bus.Stall_Fetch, 32'(bus.IF_Req && !exp_if_ack));
            chk("stall_mem", bus.Stall_Mem, 32'(bus.MEM_Req && !exp_mem_ack));
         end
         nfin++;
      end
   end

   initial begin
      fork
         wait (nfin == 2);
         #1_000_000;
      join_any
      if (nfin != 2) begin
         total++;
         bad++;
         $display("FAIL timeout: finished=%0d expected=2", nfin);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
